// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO controller and its RAM.
package sync_fifo_pkg;

    // Output pipeline modes for the PIPE parameter
    localparam int unsigned PIPE_NONE = 0;
    localparam int unsigned PIPE_OUT  = 1;

    // Ceiling log2, used to size pointers and the word counter
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register has a synchronous reset so the FIFO output starts at zero.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port; contents are never cleared
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, holds its value when no read is issued
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, word count, status flags and the
// read-data output pipeline around a sync_fifo_ram instance.
// Optional feature macro: SYNC_FIFO_ERRFLAG_EN enables the sticky
// OVERFLOW/UNDERFLOW flags; when undefined both ports are tied low.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned PIPE      = 1,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    WE,
    input  logic [WIDTH-1:0]        WDATA,
    input  logic                    RE,
    output logic [WIDTH-1:0]        RDATA,
    output logic                    RVALID,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    AFULL,
    output logic                    AEMPTY,
    output logic [clog2(DEPTH):0]   COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] L_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] L_AFULL  = CW'(AFULL_TH);
    localparam logic [CW-1:0] L_AEMPTY = CW'(AEMPTY_TH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             r_rv1;
    logic [WIDTH-1:0] w_ram_q;

    // Accept decisions use only registered flags; next count from accepts
    always_comb begin
        w_wr_acc    = WE & ~r_full;
        w_rd_acc    = RE & ~r_empty;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, counter and flags, flags registered from the next count
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == L_FULL);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= L_AFULL);
            r_aempty <= (w_count_nxt <= L_AEMPTY);
        end
    end

    // First read-valid stage tracks the RAM read register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rv1 <= 1'b0;
        end else begin
            r_rv1 <= w_rd_acc;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (WDATA),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    generate
        if (PIPE == PIPE_OUT) begin : g_pipe_out
            logic             r_rv2;
            logic [WIDTH-1:0] r_rdata;

            // Extra output register stage; reset drops any in-flight read
            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    r_rv2   <= 1'b0;
                    r_rdata <= '0;
                end else begin
                    r_rv2 <= r_rv1;
                    if (r_rv1) begin
                        r_rdata <= w_ram_q;
                    end
                end
            end

            assign RDATA  = r_rdata;
            assign RVALID = r_rv2;
        end else begin : g_pipe_none
            assign RDATA  = w_ram_q;
            assign RVALID = r_rv1;
        end
    endgenerate

`ifdef SYNC_FIFO_ERRFLAG_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags for dropped writes and ignored reads
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (WE && r_full) begin
                r_overflow <= 1'b1;
            end
            if (RE && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign OVERFLOW  = r_overflow;
    assign UNDERFLOW = r_underflow;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign FULL   = r_full;
    assign EMPTY  = r_empty;
    assign AFULL  = r_afull;
    assign AEMPTY = r_aempty;
    assign COUNT  = r_count;

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 128, word count; power of 2, 4..4096.
REQ-003 SHALL have parameter PIPE, default 1: 0 = read data one cycle after accept, 1 = extra output register, two cycles.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-4, almost-full threshold.
REQ-005 SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold.
REQ-006 SHALL have port CLOCK  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-008 SHALL have port WE  in  1  write request.
REQ-009 SHALL have port WDATA  in  WIDTH  write data.
REQ-010 SHALL have port RE  in  1  read request.
REQ-011 SHALL have port RDATA  out  WIDTH  read data.
REQ-012 SHALL have port RVALID  out  1  RDATA valid strobe, one cycle per accepted read.
REQ-013 SHALL have ports FULL, EMPTY, AFULL, AEMPTY  out  1 each  status flags.
REQ-014 SHALL have port COUNT  out  clog2(DEPTH)+1  words stored.
REQ-015 SHALL have ports OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when WE=1 and FULL=0; WE with FULL=1 SHALL be dropped, even if RE is accepted in that cycle.
REQ-017 SHALL accept a read when RE=1 and EMPTY=0; RE with EMPTY=1 SHALL be ignored, even if WE is accepted in that cycle.
REQ-018 SHALL keep write and read pointers of clog2(DEPTH) bits, each incrementing by 1 per accepted operation and wrapping from DEPTH-1 to 0.
REQ-019 SHALL update COUNT registered: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-020 SHALL drive FULL = (COUNT==DEPTH), EMPTY = (COUNT==0), AFULL = (COUNT>=AFULL_TH), AEMPTY = (COUNT<=AEMPTY_TH), all from registered COUNT, no combinational path from WE/RE.
REQ-021 SHALL present the word at the read pointer on RDATA with RVALID=1 exactly 1 (PIPE=0) or 2 (PIPE=1) cycles after the accepted read; RDATA SHALL hold its last value while RVALID=0.
REQ-022 SHALL return words in write order; a word written in cycle N SHALL be readable by an RE accepted in cycle N+1 at the earliest (no write-to-read bypass).
REQ-023 SHALL sustain one write and one read per cycle indefinitely at any COUNT other than 0 and DEPTH.

Reset
REQ-024 SHALL, while RESET=1 at a clock edge, clear pointers and COUNT to 0, set EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, RVALID=0, RDATA=0, OVERFLOW=0, UNDERFLOW=0.
REQ-025 SHALL discard any read in the PIPE pipeline when RESET asserts mid-operation; no RVALID SHALL emerge after reset from a pre-reset read.
REQ-026 SHALL not require RAM contents to be cleared; stale contents SHALL never be visible as valid data.

Configuration
REQ-027 SHALL, with macro SYNC_FIFO_ERRFLAG_EN defined, set OVERFLOW on a dropped write (REQ-016) and UNDERFLOW on an ignored read (REQ-017), each held until RESET.
REQ-028 SHALL, without SYNC_FIFO_ERRFLAG_EN, keep OVERFLOW and UNDERFLOW ports present and tied to 0, with no error logic synthesised.

Structure
REQ-029 SHALL place in shared package sync_fifo_pkg: pointer-width function (clog2), PIPE mode constants (PIPE_NONE=0, PIPE_OUT=1).
REQ-030 SHALL instantiate one sub-module sync_fifo_ram: simple dual-port RAM, one write port, one registered read port, WIDTH x DEPTH, inferrable to LSRAM; control, flags and output pipeline stay in sync_fifo_ctrl.

Verification
REQ-031 SHALL cover reset: RESET=1 two cycles with WE=RE=1 -> COUNT=0, EMPTY=1, RVALID never 1, after release EMPTY=1.
REQ-032 SHALL cover fill/drain, DEPTH=8, PIPE=1: write 0x01..0x08 -> FULL=1 after 8th write, AFULL=1 at COUNT=4; read 8 -> RDATA 0x01..0x08 in order, each RVALID 2 cycles after RE, EMPTY=1 after last.
REQ-033 SHALL cover full boundary: FULL=1, WE=1, RE=1 with 0xAA -> read accepted, write dropped, COUNT=7, OVERFLOW=1 (macro defined) or 0 (undefined).
REQ-034 SHALL cover empty boundary: EMPTY=1, WE=1 with 0x55, RE=1 -> COUNT=1, no RVALID, UNDERFLOW=1 (macro defined); next-cycle RE returns 0x55.
REQ-035 SHALL cover wrap: DEPTH=8, PIPE=0, 20 cycles simultaneous WE/RE at COUNT=3 with incrementing data -> COUNT stays 3, output sequence gap-free, RDATA one cycle after each RE.
REQ-036 SHALL cover reset mid-read: PIPE=1, RE accepted, RESET next cycle -> no RVALID, COUNT=0.
